fir_host_ctrl: RTL
==================

// Module: fir_host_ctrl
// PURPOSE
// AXI-lite master / AXI-stream driver for the FIR engine: the initiator side of its control and data ports.
// On a start pulse it writes Tape_Num coefficients, data length and ap_start.
// It then streams len samples into ss_*, collects len results from sm_*, and polls ap_state until ap_done.
// Sits between the test/firmware sequencer and the fir block.
// PARAMETERS
// pADDR_WIDTH  12    AXI-lite address width
// pDATA_WIDTH  32    data/coef/result width
// Tape_Num     11    number of coefficients written (addr 0x20 + 4*k)
// POLL_MAX     1024  ap_state reads before timeout error
// PORTS
// axis_clk   in   1     clock, all logic on rising edge
// axis_rst_n in   1     synchronous active-low reset
// start      in   1     1-cycle command pulse
// len        in   10    sample count, sampled on start
// coef_idx   out  4     coefficient index requested
// coef_data  in   32    coefficient for coef_idx (combinational source)
// src_valid  in   1     input sample available
// src_data   in   32    input sample X[n]
// src_ready  out  1     sample consumed (= ss_tvalid & ss_tready)
// res_valid  out  1     result Y[n] valid (1 cycle)
// res_data   out  32    result Y[n]
// busy/done/err out 1 each  status; done, err are 1-cycle pulses
// awvalid,awaddr[pADDR_WIDTH],wvalid,wdata[32] out; awready,wready in   AXI-lite write
// arvalid,araddr[pADDR_WIDTH],rready out; arready,rvalid,rdata[32] in    AXI-lite read
// ss_tvalid,ss_tdata[32],ss_tlast out; ss_tready in                    AXI-stream to FIR
// sm_tvalid,sm_tdata[32],sm_tlast in; sm_tready out                    AXI-stream from FIR
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0; reset mid-operation aborts at next edge, no pending beat kept.
// - FSM: IDLE -> WR_TAP (k=0..Tape_Num-1) -> WR_LEN (0x10, data=len) -> WR_START (0x00, data=1)
//   -> STREAM -> POLL -> IDLE (done pulse).
// - start ignored when busy; start with len==0: err pulse, stay IDLE.
// - busy=1 from cycle after accepted start until the cycle done/err pulses.
// - Write txn: awvalid & wvalid raised same cycle with addr/data; each drops the cycle after its own ready.
//   Txn completes when both seen (any order or same cycle); next txn starts the following cycle.
// - coef_idx=k during WR_TAP; wdata latched from coef_data when the txn issues.
// - STREAM: ss_tvalid=src_valid while in_cnt<len; ss_tdata=src_data; ss_tlast=(in_cnt==len-1).
//   sm_tready=1 while out_cnt<len.
//   Each sm beat: res_valid=1, res_data=sm_tdata next cycle, out_cnt++.
//   Exit when in_cnt==len and out_cnt==len.
// - sm_tlast on a beat with out_cnt!=len-1, or missing on beat len-1: err pulse, result still forwarded, continue.
// - POLL: araddr=0x00, arvalid until arready, rready=1 until rvalid.
//   rdata[1]=1 -> done; else reissue next cycle.
//   POLL_MAX reads without ap_done -> err, IDLE.
// - Counters 10-bit, no wrap (max len 1023); AXI addresses word-aligned; no arithmetic on data.
// TESTING
// - Reset mid-WR_TAP (k=5): all outputs 0 next edge, busy=0; new start restarts at k=0.
// - start,len=3, coef k=k+1, awready/wready same cycle: 11 writes to 0x20..0x48, then 0x10=3, 0x00=1.
// - wready 2 cycles before awready: write completes once, no duplicate awvalid beat.
// - Stream X=1,2,3; FIR returns 1,4,10 with tlast on 3rd: res_data 1,4,10; ss_tlast on 3rd input; done after poll sees 0x6.
// - src_valid low 4 cycles mid-stream and sm_tvalid stalled: no beats lost, in/out counts both 3.
// - sm_tlast on beat 1 of len=3: err pulse; ap_done never set: err after 1024 reads, busy=0.

Source files
------------

// File: rtl/fir_host_ctrl.sv
// Host-side sequencer for the FIR engine: programs taps, length and ap_start over AXI-lite,
// streams samples in and results out over AXI-stream, then polls ap_state for ap_done.
module fir_host_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int POLL_MAX    = 1024
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   start,
  input  logic [9:0]             len,
  output logic [3:0]             coef_idx,
  input  logic [pDATA_WIDTH-1:0] coef_data,
  input  logic                   src_valid,
  input  logic [pDATA_WIDTH-1:0] src_data,
  output logic                   src_ready,
  output logic                   res_valid,
  output logic [pDATA_WIDTH-1:0] res_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   awready,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rready,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready,
  input  logic                   sm_tvalid,
  input  logic [pDATA_WIDTH-1:0] sm_tdata,
  input  logic                   sm_tlast,
  output logic                   sm_tready
);
  // state      | meaning
  // S_IDLE     | waiting for start
  // S_WR_TAP   | writing coefficient k to 0x20 + 4k
  // S_WR_LEN   | writing data length to 0x10
  // S_WR_START | writing ap_start to 0x00
  // S_STREAM   | pushing samples to ss_*, collecting results from sm_*
  // S_POLL     | reading ap_state until ap_done or timeout
  typedef enum logic [2:0] {S_IDLE, S_WR_TAP, S_WR_LEN, S_WR_START, S_STREAM, S_POLL} state_t;

  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam logic [pADDR_WIDTH-1:0] A_CTRL = pADDR_WIDTH'('h00);
  localparam logic [pADDR_WIDTH-1:0] A_LEN  = pADDR_WIDTH'('h10);
  localparam logic [pADDR_WIDTH-1:0] A_TAP  = pADDR_WIDTH'('h20);
  localparam logic [3:0]             K_LAST = 4'(Tape_Num - 1);

  state_t                 state_q, state_d;
  logic [9:0]             len_q, len_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [3:0]             k_q, k_d;
  logic [PCW-1:0]         poll_cnt_q, poll_cnt_d;
  logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                   res_valid_q, res_valid_d;
  logic [pDATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                   aw_seen_q, aw_seen_d, w_seen_q, w_seen_d;
  logic [pADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                   arvalid_q, arvalid_d, rready_q, rready_d;

  logic                   aw_ok, w_ok, txn_done, tap_adv, in_stream, sm_hs;
  logic                   issue;
  logic [pADDR_WIDTH-1:0] iss_addr;
  logic [pDATA_WIDTH-1:0] iss_data;
  logic                   unused_rdata;

  // A write completes once both channels have handshaked, in either order.
  assign aw_ok    = aw_seen_q | (awvalid_q & awready);
  assign w_ok     = w_seen_q | (wvalid_q & wready);
  assign txn_done = aw_ok & w_ok;
  // Point coef_idx at the next tap on the completing edge so its wdata can issue back-to-back.
  assign tap_adv  = (state_q == S_WR_TAP) && txn_done && (k_q != K_LAST);
  assign coef_idx = tap_adv ? k_q + 4'd1 : ((state_q == S_WR_TAP) ? k_q : 4'd0);

  assign in_stream = (state_q == S_STREAM);
  assign ss_tvalid = in_stream & src_valid & (in_cnt_q < len_q);
  assign ss_tdata  = in_stream ? src_data : '0;
  assign ss_tlast  = in_stream & (in_cnt_q < len_q) & (in_cnt_q == len_q - 10'd1);
  assign src_ready = ss_tvalid & ss_tready;
  assign sm_tready = in_stream & (out_cnt_q < len_q);
  assign sm_hs     = sm_tvalid & sm_tready;

  assign unused_rdata = ^{rdata[pDATA_WIDTH-1:2], rdata[0]};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    k_d         = coef_idx;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    awvalid_d   = awvalid_q & ~awready;
    wvalid_d    = wvalid_q & ~wready;
    aw_seen_d   = aw_ok & ~txn_done;
    w_seen_d    = w_ok & ~txn_done;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    arvalid_d   = arvalid_q & ~arready;
    rready_d    = rready_q & ~rvalid;
    issue       = 1'b0;
    iss_addr    = awaddr_q;
    iss_data    = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == 10'd0) begin
            err_d = 1'b1;
          end else begin
            len_d      = len;
            busy_d     = 1'b1;
            in_cnt_d   = '0;
            out_cnt_d  = '0;
            poll_cnt_d = '0;
            state_d    = S_WR_TAP;
            issue      = 1'b1;
            iss_addr   = A_TAP;
            iss_data   = coef_data;
          end
        end
      end
      S_WR_TAP: begin
        if (txn_done) begin
          issue = 1'b1;
          if (k_q == K_LAST) begin
            state_d  = S_WR_LEN;
            iss_addr = A_LEN;
            iss_data = pDATA_WIDTH'(len_q);
          end else begin
            iss_addr = A_TAP + pADDR_WIDTH'({coef_idx, 2'b00});
            iss_data = coef_data;
          end
        end
      end
      S_WR_LEN: begin
        if (txn_done) begin
          state_d  = S_WR_START;
          issue    = 1'b1;
          iss_addr = A_CTRL;
          iss_data = pDATA_WIDTH'(1);
        end
      end
      S_WR_START: begin
        if (txn_done) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (src_ready) in_cnt_d = in_cnt_q + 10'd1;
        if (sm_hs) begin
          res_valid_d = 1'b1;
          res_data_d  = sm_tdata;
          out_cnt_d   = out_cnt_q + 10'd1;
          if (sm_tlast != (out_cnt_q == len_q - 10'd1)) err_d = 1'b1;
        end
        if (in_cnt_q == len_q && out_cnt_q == len_q) begin
          state_d   = S_POLL;
          arvalid_d = 1'b1;
          rready_d  = 1'b1;
        end
      end
      S_POLL: begin
        if (rvalid && rready_q) begin
          poll_cnt_d = poll_cnt_q + PCW'(1);
          if (rdata[1]) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (poll_cnt_q == PCW'(POLL_MAX - 1)) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      aw_seen_d = 1'b0;
      w_seen_d  = 1'b0;
      awaddr_d  = iss_addr;
      wdata_d   = iss_data;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      k_q         <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      poll_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_seen_q   <= 1'b0;
      w_seen_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      k_q         <= k_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_seen_q   <= aw_seen_d;
      w_seen_q    <= w_seen_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign arvalid   = arvalid_q;
  assign araddr    = A_CTRL;
  assign rready    = rready_q;

endmodule
